// File: rtl/silent_lpf_sequencer.sv
// ---------------------------------------------------------------------------
// silent_lpf_sequencer
//
// Schedules update frames for the silent LPF datapath. A free-running period
// counter, or an external SYNC pulse, produces a tick. Each tick seen in IDLE
// launches one frame:
//   1. issue a one-cycle LPF_UPDATE strobe;
//   2. wait for the rising edge of LPF_OUT_VALID that marks the end of the frame.
//
// STEP/ENABLE are written into shadow registers at any time. They are copied
// to the active outputs only when a frame is launched, so the LPF sees stable
// values for a whole frame. Ticks that arrive while a frame is in flight are
// coalesced into a single pending request. Further ticks are counted as
// overruns in a saturating counter.
//
// Optional feature (compile-time macro SILENT_WATCHDOG_EN):
//   A watchdog aborts a WAIT that lasts WDT_CYCLES cycles and sets the sticky
//   TIMEOUT flag. Without the macro, WAIT never times out and TIMEOUT is 0.
//
// Parameters
//   WIDTH       width of STEP
//   PW          width of period counter / CFG_PERIOD
//   CW          width of OVERRUN_CNT (saturating)
//   STEP_INIT   reset value of shadow and active STEP
//   WDT_CYCLES  watchdog limit in WAIT (only with SILENT_WATCHDOG_EN)
//
// Ports
//   CLK            in   system clock, all logic on posedge
//   RST            in   synchronous reset, active-high
//   CFG_WE         in   load CFG_STEP/CFG_ENABLE into the shadow registers
//   CFG_STEP       in   new step value
//   CFG_ENABLE     in   new LPF enable value
//   CFG_PERIOD     in   tick period in cycles (0 = SYNC-only), sampled live
//   SYNC           in   realigns the period counter and forces a tick
//   LPF_OUT_VALID  in   LPF frame-complete level
//   LPF_UPDATE     out  one-cycle update strobe to the LPF
//   LPF_STEP       out  active step
//   LPF_ENABLE     out  active enable
//   BUSY           out  frame in flight (ISSUE or WAIT)
//   FRAME_DONE     out  one-cycle pulse on accepted completion
//   OVERRUN_CNT    out  saturating count of dropped ticks
//   TIMEOUT        out  sticky watchdog flag
// ---------------------------------------------------------------------------
// state | meaning
// ------+-------------------------------------------------------------------
// IDLE  | no frame in flight; a tick or a pending request launches a frame
// ISSUE | LPF_UPDATE is high for this single cycle
// WAIT  | waiting for the LPF_OUT_VALID rising edge (or watchdog expiry)
// ---------------------------------------------------------------------------
module silent_lpf_sequencer #(
  parameter int               WIDTH      = 13,
  parameter int               PW         = 16,
  parameter int               CW         = 8,
  parameter logic [WIDTH-1:0] STEP_INIT  = WIDTH'(1),
  parameter int               WDT_CYCLES = 1024
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CFG_WE,
  input  logic [WIDTH-1:0] CFG_STEP,
  input  logic             CFG_ENABLE,
  input  logic [PW-1:0]    CFG_PERIOD,
  input  logic             SYNC,
  input  logic             LPF_OUT_VALID,
  output logic             LPF_UPDATE,
  output logic [WIDTH-1:0] LPF_STEP,
  output logic             LPF_ENABLE,
  output logic             BUSY,
  output logic             FRAME_DONE,
  output logic [CW-1:0]    OVERRUN_CNT,
  output logic             TIMEOUT
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [PW-1:0]    cnt;
  logic [PW-1:0]    cnt_nxt;
  logic             period_nz;
  logic             nat_tick;
  logic             tick;

  logic             pending;
  logic             valid_d;
  logic             done;

  logic [WIDTH-1:0] sh_step;
  logic             sh_en;
  logic [WIDTH-1:0] act_step;
  logic             act_en;
  logic [CW-1:0]    ovr_cnt;

  logic             load_active;
  logic             clr_pending;
  logic             set_pending;
  logic             inc_ovr;
  logic             wdt_expire;
  logic             set_timeout;

  // -------------------------------------------------------------------------
  // Tick generation
  // -------------------------------------------------------------------------
  // With a non-zero period, the counter runs 0..CFG_PERIOD-1. If the period
  // is lowered below the current count, the counter runs on and wraps through
  // all-ones before it can match again. SYNC and a natural tick in the same
  // cycle collapse into a single tick because both simply feed the same OR.
  assign period_nz = |CFG_PERIOD;
  assign nat_tick  = period_nz && (cnt == (CFG_PERIOD - PW'(1)));
  assign tick      = nat_tick | SYNC;

  always_comb begin
    cnt_nxt = cnt + PW'(1);
    if (SYNC || !period_nz || nat_tick) begin
      cnt_nxt = '0;
    end
  end

  // Completion is the rising edge of LPF_OUT_VALID. If the level is still
  // high from the previous frame, it is not treated as a new completion.
  assign done = LPF_OUT_VALID & ~valid_d;

  // -------------------------------------------------------------------------
  // Watchdog
  // -------------------------------------------------------------------------
`ifdef SILENT_WATCHDOG_EN
  localparam int WDW = $clog2(WDT_CYCLES) + 1;

  logic [WDW-1:0] wdt;
  logic           timeout_q;

  assign wdt_expire = (wdt == WDW'(WDT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      wdt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      // Cleared while in ISSUE, so it reads 0 on the first WAIT cycle.
      if (state == S_ISSUE) begin
        wdt <= '0;
      end else if (state == S_WAIT) begin
        wdt <= wdt + WDW'(1);
      end
      if (set_timeout) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign TIMEOUT = timeout_q;
`else
  logic unused_wdt;

  assign unused_wdt = (WDT_CYCLES == 0);
  assign wdt_expire = 1'b0;
  assign TIMEOUT    = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    LPF_UPDATE  = 1'b0;
    BUSY        = 1'b0;
    FRAME_DONE  = 1'b0;
    load_active = 1'b0;
    clr_pending = 1'b0;
    set_pending = 1'b0;
    inc_ovr     = 1'b0;
    set_timeout = 1'b0;

    case (state)
      S_IDLE: begin
        if (tick || pending) begin
          state_nxt   = S_ISSUE;
          load_active = 1'b1;
          clr_pending = 1'b1;
        end
      end

      S_ISSUE: begin
        LPF_UPDATE = 1'b1;
        BUSY       = 1'b1;
        state_nxt  = S_WAIT;
      end

      S_WAIT: begin
        BUSY = 1'b1;
        if (done) begin
          state_nxt  = S_IDLE;
          FRAME_DONE = 1'b1;
        end else if (wdt_expire) begin
          state_nxt   = S_IDLE;
          set_timeout = 1'b1;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Ticks during a frame, including the completion cycle, are coalesced:
    // the first one is held as pending, and later ones count as overruns.
    if ((state == S_ISSUE || state == S_WAIT) && tick) begin
      if (pending) begin
        inc_ovr = 1'b1;
      end else begin
        set_pending = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt      <= '0;
      pending  <= 1'b0;
      valid_d  <= 1'b0;
      sh_step  <= STEP_INIT;
      sh_en    <= 1'b0;
      act_step <= STEP_INIT;
      act_en   <= 1'b0;
      ovr_cnt  <= '0;
    end else begin
      cnt     <= cnt_nxt;
      valid_d <= LPF_OUT_VALID;

      // The copy to the active registers reads the old shadow value. A
      // CFG_WE in the launch cycle therefore lands in the shadow registers
      // only and takes effect at the next frame.
      if (load_active) begin
        act_step <= sh_step;
        act_en   <= sh_en;
      end
      if (CFG_WE) begin
        sh_step <= CFG_STEP;
        sh_en   <= CFG_ENABLE;
      end

      if (clr_pending) begin
        pending <= 1'b0;
      end else if (set_pending) begin
        pending <= 1'b1;
      end

      if (inc_ovr && (ovr_cnt != {CW{1'b1}})) begin
        ovr_cnt <= ovr_cnt + CW'(1);
      end
    end
  end

  assign LPF_STEP    = act_step;
  assign LPF_ENABLE  = act_en;
  assign OVERRUN_CNT = ovr_cnt;

endmodule

// File: tb/tb_silent_lpf_sequencer.sv
module tb_silent_lpf_sequencer;

  localparam int WIDTH = 13;
  localparam int PW    = 16;
  localparam int CW    = 8;
  localparam int WDT   = 64;

  logic             CLK = 1'b0;
  logic             RST;
  logic             CFG_WE;
  logic [WIDTH-1:0] CFG_STEP;
  logic             CFG_ENABLE;
  logic [PW-1:0]    CFG_PERIOD;
  logic             SYNC;
  logic             LPF_OUT_VALID;
  logic             LPF_UPDATE;
  logic [WIDTH-1:0] LPF_STEP;
  logic             LPF_ENABLE;
  logic             BUSY;
  logic             FRAME_DONE;
  logic [CW-1:0]    OVERRUN_CNT;
  logic             TIMEOUT;

  always #5 CLK = ~CLK;

  silent_lpf_sequencer #(
    .WIDTH(WIDTH), .PW(PW), .CW(CW), .STEP_INIT(13'd1), .WDT_CYCLES(WDT)
  ) dut (
    .CLK(CLK), .RST(RST), .CFG_WE(CFG_WE), .CFG_STEP(CFG_STEP),
    .CFG_ENABLE(CFG_ENABLE), .CFG_PERIOD(CFG_PERIOD), .SYNC(SYNC),
    .LPF_OUT_VALID(LPF_OUT_VALID), .LPF_UPDATE(LPF_UPDATE), .LPF_STEP(LPF_STEP),
    .LPF_ENABLE(LPF_ENABLE), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE),
    .OVERRUN_CNT(OVERRUN_CNT), .TIMEOUT(TIMEOUT)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model, expressed as a frame-in-flight flag plus the age of that
  // frame in cycles (age 0 is the UPDATE cycle).
  int             m_cnt      = 0;
  bit             m_busy     = 0;
  int             m_age      = 0;
  bit             m_pend     = 0;
  int             m_ovr      = 0;
  logic [12:0]    m_sh_step  = 13'd1;
  bit             m_sh_en    = 0;
  logic [12:0]    m_act_step = 13'd1;
  bit             m_act_en   = 0;
  bit             m_vprev    = 0;
  bit             m_tout     = 0;

  // Behavioural LPF: after an UPDATE, valid drops for lpf_delay-1 cycles and
  // then rises and holds high.
  bit lpf_auto  = 1;
  bit lpf_valid = 0;
  int lpf_cnt   = 0;
  int lpf_delay = 40;

  int dut_upd  = 0;
  int dut_done = 0;

  typedef struct {
    int period;
    int delay;
    int ncyc;
    int s0;
    int s1;
    int s2;
    int exp_upd;
    int exp_done;
    int exp_ovr;
  } scn_t;

  scn_t tbl[5];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // One clock cycle. The caller has already driven the inputs for this cycle.
  // Outputs are compared at the negedge, and the model advances at the posedge.
  task automatic step();
    bit tick, done, e_upd, wdt_hit;
    LPF_OUT_VALID = lpf_valid;
    @(negedge CLK);
    tick    = SYNC || (CFG_PERIOD != 0 && m_cnt == int'(CFG_PERIOD) - 1);
    done    = m_busy && m_age >= 1 && LPF_OUT_VALID && !m_vprev;
    wdt_hit = 0;
`ifdef SILENT_WATCHDOG_EN
    wdt_hit = m_busy && m_age == WDT && !done;
`endif
    e_upd = m_busy && m_age == 0;
    n_checks++;
    if ({LPF_UPDATE, BUSY, FRAME_DONE, LPF_ENABLE, TIMEOUT} !== {e_upd, m_busy, done, m_act_en, m_tout}
        || LPF_STEP !== m_act_step || OVERRUN_CNT !== 8'(m_ovr)) begin
      n_fail++;
      $display("FAIL cycle_outputs t=%0t: got upd=%b busy=%b done=%b en=%b tout=%b step=%0d ovr=%0d, expected upd=%b busy=%b done=%b en=%b tout=%b step=%0d ovr=%0d",
               $time, LPF_UPDATE, BUSY, FRAME_DONE, LPF_ENABLE, TIMEOUT, LPF_STEP, OVERRUN_CNT,
               e_upd, m_busy, done, m_act_en, m_tout, m_act_step, m_ovr);
    end
    if (LPF_UPDATE === 1'b1) dut_upd++;
    if (FRAME_DONE === 1'b1) dut_done++;
    @(posedge CLK);
    if (RST) begin
      m_cnt = 0; m_busy = 0; m_age = 0; m_pend = 0; m_ovr = 0;
      m_sh_step = 13'd1; m_sh_en = 0; m_act_step = 13'd1; m_act_en = 0;
      m_vprev = 0; m_tout = 0;
    end else begin
      if (tick || CFG_PERIOD == 0) m_cnt = 0;
      else m_cnt = (m_cnt + 1) % 65536;
      if (!m_busy) begin
        if (tick || m_pend) begin
          m_busy = 1; m_age = 0; m_pend = 0;
          m_act_step = m_sh_step; m_act_en = m_sh_en;
        end
      end else begin
        if (tick) begin
          if (m_pend) m_ovr = (m_ovr < 255) ? m_ovr + 1 : 255;
          else m_pend = 1;
        end
        if (done) m_busy = 0;
        else if (wdt_hit) begin m_busy = 0; m_tout = 1; end
        else m_age++;
      end
      if (CFG_WE) begin m_sh_step = CFG_STEP; m_sh_en = CFG_ENABLE; end
      m_vprev = LPF_OUT_VALID;
    end
    if (lpf_auto) begin
      if (e_upd) begin
        lpf_valid = 0;
        lpf_cnt   = lpf_delay - 1;
      end else if (lpf_cnt > 0) begin
        lpf_cnt--;
        if (lpf_cnt == 0) lpf_valid = 1;
      end
    end
    #1;
  endtask

  task automatic do_reset(input int n);
    RST = 1;
    repeat (n) step();
    RST = 0;
    lpf_valid = 0;
    lpf_cnt   = 0;
  endtask

  task automatic run_scn(input int idx, input scn_t s);
    CFG_PERIOD = PW'(s.period);
    lpf_delay  = s.delay;
    SYNC = 0; CFG_WE = 0;
    do_reset(3);
    dut_upd = 0; dut_done = 0;
    for (int i = 0; i < s.ncyc; i++) begin
      SYNC = (i == s.s0 || i == s.s1 || i == s.s2);
      step();
    end
    SYNC = 0;
    check($sformatf("scn%0d_updates", idx), 64'(dut_upd), 64'(s.exp_upd));
    check($sformatf("scn%0d_frame_done", idx), 64'(dut_done), 64'(s.exp_done));
    check($sformatf("scn%0d_overrun", idx), 64'(OVERRUN_CNT), 64'(s.exp_ovr));
  endtask

  initial begin
    int d0;
    // period, delay, ncyc, sync0..2, expected updates / frame_dones / overruns
    tbl[0] = '{100, 40, 1000, -1, -1, -1, 9, 9, 0};
    tbl[1] = '{30,  50, 300,  -1, -1, -1, 6, 5, 3};
    tbl[2] = '{0,   40, 300,  10, 200, -1, 2, 2, 0};
    tbl[3] = '{50,  10, 200,  49, -1, -1, 3, 3, 0};
    tbl[4] = '{0,   40, 150,  10, 20, 30, 2, 2, 1};

    RST = 1; CFG_WE = 0; CFG_STEP = '0; CFG_ENABLE = 0; CFG_PERIOD = '0;
    SYNC = 0; LPF_OUT_VALID = 0;
    @(posedge CLK); #1;

    // Reset state
    do_reset(3);
    check("rst_update", 64'(LPF_UPDATE), 0);
    check("rst_busy", 64'(BUSY), 0);
    check("rst_frame_done", 64'(FRAME_DONE), 0);
    check("rst_overrun", 64'(OVERRUN_CNT), 0);
    check("rst_timeout", 64'(TIMEOUT), 0);
    check("rst_step", 64'(LPF_STEP), 1);
    check("rst_enable", 64'(LPF_ENABLE), 0);

    for (int i = 0; i < 5; i++) run_scn(i, tbl[i]);

    // Shadow registers apply only at frame launch
    CFG_PERIOD = '0; lpf_delay = 20;
    do_reset(2);
    CFG_WE = 1; CFG_STEP = 13'd7; CFG_ENABLE = 1; step(); CFG_WE = 0;
    SYNC = 1; step(); SYNC = 0;
    check("shadow_first_update", 64'(LPF_UPDATE), 1);
    check("shadow_first_step", 64'(LPF_STEP), 7);
    check("shadow_first_enable", 64'(LPF_ENABLE), 1);
    repeat (5) step();
    CFG_WE = 1; CFG_STEP = 13'd5; CFG_ENABLE = 0; step(); CFG_WE = 0;
    check("shadow_step_held_in_wait", 64'(LPF_STEP), 7);
    check("shadow_enable_held_in_wait", 64'(LPF_ENABLE), 1);
    repeat (30) step();
    SYNC = 1; CFG_WE = 1; CFG_STEP = 13'd9; CFG_ENABLE = 1; step();
    SYNC = 0; CFG_WE = 0;
    check("shadow_launch_cycle_update", 64'(LPF_UPDATE), 1);
    check("shadow_launch_cycle_old_step", 64'(LPF_STEP), 5);
    check("shadow_launch_cycle_old_enable", 64'(LPF_ENABLE), 0);
    repeat (30) step();
    SYNC = 1; step(); SYNC = 0;
    check("shadow_next_frame_step", 64'(LPF_STEP), 9);

    // Reset during WAIT, then a late completion edge
    lpf_delay = 40;
    SYNC = 1; step(); SYNC = 0;
    repeat (10) step();
    check("midframe_busy", 64'(BUSY), 1);
    RST = 1; repeat (300) step(); RST = 0;
    check("post_rst_busy", 64'(BUSY), 0);
    check("post_rst_step", 64'(LPF_STEP), 1);
    check("post_rst_overrun", 64'(OVERRUN_CNT), 0);
    lpf_auto = 0; lpf_valid = 0;
    d0 = dut_done;
    repeat (3) step();
    lpf_valid = 1;
    repeat (10) step();
    check("late_edge_no_frame_done", 64'(dut_done - d0), 0);
    check("late_edge_still_idle", 64'(BUSY), 0);
    lpf_auto = 1;

    // Overrun saturation: one tick per cycle
    CFG_PERIOD = 16'd1; lpf_delay = 20;
    do_reset(2);
    repeat (400) step();
    check("overrun_saturates", 64'(OVERRUN_CNT), 255);

`ifdef SILENT_WATCHDOG_EN
    // LPF never completes
    CFG_PERIOD = '0; lpf_delay = 1000000;
    do_reset(2);
    SYNC = 1; step(); SYNC = 0;
    check("wdt_issue", 64'(LPF_UPDATE), 1);
    repeat (64) step();
    check("wdt_before_expiry_busy", 64'(BUSY), 1);
    check("wdt_before_expiry_timeout", 64'(TIMEOUT), 0);
    step();
    check("wdt_timeout_set", 64'(TIMEOUT), 1);
    check("wdt_back_idle", 64'(BUSY), 0);
    SYNC = 1; step(); SYNC = 0;
    check("wdt_next_update", 64'(LPF_UPDATE), 1);
    check("wdt_timeout_sticky", 64'(TIMEOUT), 1);
    do_reset(2);
    check("wdt_timeout_cleared", 64'(TIMEOUT), 0);
`endif

    // Randomized segments checked cycle by cycle against the model
    do_reset(2);
    for (int seg = 0; seg < 6; seg++) begin
      CFG_PERIOD = ($urandom_range(0, 3) == 0) ? 16'd0 : PW'($urandom_range(1, 80));
      lpf_delay  = $urandom_range(3, 60);
      SYNC = 1; step(); SYNC = 0;
      for (int i = 0; i < 500; i++) begin
        SYNC       = ($urandom_range(0, 49) == 0);
        CFG_WE     = ($urandom_range(0, 9) == 0);
        CFG_STEP   = WIDTH'($urandom);
        CFG_ENABLE = 1'($urandom);
        RST        = ($urandom_range(0, 399) == 0);
        step();
      end
      RST = 0; CFG_WE = 0; SYNC = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
